// File: rtl/div_pkg.sv
// Shared constants for the iterative divider: FSM encoding and result layout.
package div_pkg;

  // FSM state encoding (2 bits).
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BYZERO = 2'd1;
  localparam logic [1:0] ON     = 2'd2;
  localparam logic [1:0] END    = 2'd3;

  // result_o is split into two WIDTH-bit halves: quotient low, remainder high.
  localparam int QUOT_HALF = 0;
  localparam int REM_HALF  = 1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and keep the difference only if it
// did not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] divisor,
  output logic             q_bit,
  output logic [WIDTH-1:0] rem_out
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] trial;

  // Trial subtract; bit WIDTH of the difference is the borrow (partial < divisor).
  always_comb begin
    partial = {rem_in, shift_in};
    trial   = partial - {1'b0, divisor};
    q_bit   = ~trial[WIDTH];
    rem_out = trial[WIDTH] ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider for the execute stage. Operands are
// captured once, divided as magnitudes over WIDTH restoring steps, then
// sign-corrected. busy_o is the stall request; ready_o/result_o are held
// until the requester drops start_i.
//
// Handshake: start_i is a level request that stays high until the result is
// consumed. A capture happens on the edge where the unit is FREE, start_i=1
// and annul_i=0. ready_o=1 marks result_o valid and both hold while start_i
// stays high; the first edge with start_i=0 consumes the result. annul_i
// cancels everything on the next edge and wins over start_i.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic [1:0]         dbg_state
);

  // Counter needs to reach WIDTH: values 0..WIDTH-1 are steps, WIDTH is the fixup cycle.
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quot;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] divisor;
  logic             neg_q;
  logic             neg_r;

  logic             q_bit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] op1_mag;
  logic [WIDTH-1:0] op2_mag;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [2*WIDTH-1:0] result_next;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in   (rem),
    .shift_in (quot[WIDTH-1]),
    .divisor  (divisor),
    .q_bit    (q_bit),
    .rem_out  (rem_step)
  );

  // Operand magnitudes at capture, sign fixup at the end, and result packing.
  always_comb begin
    op1_mag  = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    op2_mag  = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    quot_fix = neg_q ? -quot : quot;
    rem_fix  = neg_r ? -rem : rem;
    result_next = '0;
    result_next[QUOT_HALF*WIDTH +: WIDTH] = quot;
    result_next[REM_HALF*WIDTH +: WIDTH]  = rem;
  end

  // Stall request: working states, or a request about to be captured.
  assign busy_o    = (state == BYZERO) || (state == ON) || ((state == FREE) && start_i);
  assign dbg_state = state;

  // FSM, step counter and datapath registers; annul_i overrides every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FREE;
      cnt      <= '0;
      quot     <= '0;
      rem      <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else if (annul_i) begin
      state    <= FREE;
      cnt      <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          if (start_i) begin
            quot    <= op1_mag;
            divisor <= op2_mag;
            rem     <= '0;
            cnt     <= '0;
            neg_q   <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_r   <= signed_div_i && opdata1_i[WIDTH-1];
            state   <= (opdata2_i == '0) ? BYZERO : ON;
          end
        end
        BYZERO: begin
          quot  <= '0;
          rem   <= '0;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
          state <= END;
        end
        ON: begin
          if (cnt == CW'(WIDTH)) begin
            quot  <= quot_fix;
            rem   <= rem_fix;
            state <= END;
          end else begin
            rem  <= rem_step;
            quot <= {quot[WIDTH-2:0], q_bit};
            cnt  <= cnt + CW'(1);
          end
        end
        END: begin
          if (start_i) begin
            result_o <= result_next;
            ready_o  <= 1'b1;
          end else begin
            ready_o <= 1'b0;
            state   <= FREE;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit at WIDTH=32 and WIDTH=8. Drivers push the
// expected result into a queue; per-DUT monitors compare result_o against the
// queue head on every cycle ready_o is high and pop when ready_o falls.
module tb_div_unit;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        sgn32 = 1'b0, start32 = 1'b0, annul32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] res32;
  logic        rdy32, busy32;
  logic [1:0]  st32;

  logic        sgn8 = 1'b0, start8 = 1'b0, annul8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] res8;
  logic        rdy8, busy8;
  logic [1:0]  st8;

  div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .signed_div_i(sgn32), .opdata1_i(a32), .opdata2_i(b32),
    .start_i(start32), .annul_i(annul32), .result_o(res32), .ready_o(rdy32),
    .busy_o(busy32), .dbg_state(st32)
  );

  div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .signed_div_i(sgn8), .opdata1_i(a8), .opdata2_i(b8),
    .start_i(start8), .annul_i(annul8), .result_o(res8), .ready_o(rdy8),
    .busy_o(busy8), .dbg_state(st8)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [63:0] exp32_q[$];
  logic [15:0] exp8_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic rdy32_q = 1'b0;
  always @(negedge clk) begin
    if (rdy32) begin
      if (exp32_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready32: got ready=1 expected no result pending");
      end else begin
        check("result32", res32, exp32_q[0]);
      end
    end else if (rdy32_q && exp32_q.size() > 0) begin
      void'(exp32_q.pop_front());
    end
    rdy32_q = rdy32;
  end

  logic rdy8_q = 1'b0;
  always @(negedge clk) begin
    if (rdy8) begin
      if (exp8_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready8: got ready=1 expected no result pending");
      end else begin
        check("result8", 64'(res8), 64'(exp8_q[0]));
      end
    end else if (rdy8_q && exp8_q.size() > 0) begin
      void'(exp8_q.pop_front());
    end
    rdy8_q = rdy8;
  end

  // ---------------- drivers ----------------
  task automatic run32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int lat, input int hold);
    int n;
    @(negedge clk);
    sgn32 = sgn; a32 = a; b32 = b; start32 = 1'b1;
    exp32_q.push_back(exp);
    #1 check("busy32_request", 64'(busy32), 64'd1);
    @(posedge clk); #1;
    // Scramble operands after capture: the unit must use its captured copies.
    a32 = $urandom; b32 = $urandom; sgn32 = 1'($urandom_range(0, 1));
    check("busy32_running", 64'(busy32), 64'd1);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (rdy32) begin
        n = i;
        break;
      end
    end
    check("latency32", 64'(n), 64'(lat));
    check("busy32_in_end", 64'(busy32), 64'd0);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    @(posedge clk); #1;
    check("free32_after_drop", 64'(st32), 64'(FREE));
    check("ready32_cleared", 64'(rdy32), 64'd0);
  endtask

  task automatic run8(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp, input int lat, input int hold);
    int n;
    @(negedge clk);
    sgn8 = sgn; a8 = a; b8 = b; start8 = 1'b1;
    exp8_q.push_back(exp);
    @(posedge clk); #1;
    a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom_range(0, 1));
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (rdy8) begin
        n = i;
        break;
      end
    end
    check("latency8", 64'(n), 64'(lat));
    repeat (hold) @(posedge clk);
    #1 check("ready8_held", 64'(rdy8), 64'd1);
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk); #1;
    check("free8_after_drop", 64'(st8), 64'(FREE));
    check("ready8_cleared", 64'(rdy8), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec32_t;

  vec32_t v32[8];

  initial begin
    v32[0] = '{1'b0, 32'd100,        32'd7,          {32'h00000002, 32'h0000000E}, 34};
    v32[1] = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   {32'hFFFFFFFF, 32'hFFFFFFFD}, 34};
    v32[2] = '{1'b0, 32'd5,          32'd0,          64'h0,                        2};
    v32[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h00000000, 32'h80000000}, 34};
    v32[4] = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD}, 34};
    v32[5] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   {32'hFFFFFFFF, 32'h00000003}, 34};
    v32[6] = '{1'b0, 32'hFFFFFFF9,   32'd2,          {32'h00000001, 32'h7FFFFFFC}, 34};
    v32[7] = '{1'b0, 32'd7,          32'd100,        {32'h00000007, 32'h00000000}, 34};

    // Reset state, asserted from time 0.
    #1;
    check("reset_ready32", 64'(rdy32), 64'd0);
    check("reset_state32", 64'(st32), 64'(FREE));
    check("reset_result32", res32, 64'd0);
    check("reset_ready8", 64'(rdy8), 64'd0);
    check("reset_state8", 64'(st8), 64'(FREE));
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run32(v32[i].sgn, v32[i].a, v32[i].b, v32[i].exp, v32[i].lat, i % 3);
    end

    // Annul at ON step 10: edges 1..10 after capture run steps 0..9.
    @(negedge clk);
    sgn32 = 1'b0; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul32 = 1'b1; start32 = 1'b0;
    @(posedge clk); #1;
    check("annul_state32", 64'(st32), 64'(FREE));
    check("annul_ready32", 64'(rdy32), 64'd0);
    check("annul_result32", res32, 64'd0);
    @(negedge clk);
    annul32 = 1'b0;
    repeat (40) @(posedge clk);
    run32(1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 34, 0);

    // Narrow instance: result held stable while start_i stays high.
    run8(1'b0, 8'd200, 8'd13, 16'h050F, 10, 5);
    run8(1'b1, 8'h80, 8'hFF, 16'h0080, 10, 1);

    // Reset mid-ON: immediate FREE, no result, new start accepted afterwards.
    @(negedge clk);
    sgn8 = 1'b0; a8 = 8'd200; b8 = 8'd13; start8 = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    start8 = 1'b0;
    #1;
    check("rst_mid_ready8", 64'(rdy8), 64'd0);
    check("rst_mid_state8", 64'(st8), 64'(FREE));
    check("rst_mid_result8", 64'(res8), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(posedge clk);
    check("rst_no_result8", 64'(rdy8), 64'd0);
    run8(1'b0, 8'd100, 8'd7, 16'h020E, 10, 0);

    repeat (3) @(negedge clk);
    check("queue32_drained", 64'(exp32_q.size()), 64'd0);
    check("queue8_drained", 64'(exp8_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
